// File: rtl/hex_display_pkg.sv
// Shared widths, 7-segment font and blink phase type for the hex display bank.
// Font is bit0=a .. bit6=g, 1 = lit.
package hex_display_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [NIB_W-1:0] nib_t;

  localparam seg_t BLANK_SEG = 7'h00;

  localparam seg_t SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_LIT  = 1'b0,
    PH_DARK = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble to 7-segment decoder driven from the package font table.
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_segs
);

  assign o_segs = SEG_FONT[i_nibble];

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit 7-segment controller: digit bank with load/shift, registered segments,
// per-digit blanking and global blink. Optional feature macro: LEADING_ZERO_BLANK_EN.
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        shift,
  input  logic [NIB_W-1:0]            shift_nibble,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic                        blink_en,
  output logic [NIB_W*NUM_DIGITS-1:0] digits_q,
  output logic [NIB_W-1:0]            shift_out,
  output logic [SEG_W*NUM_DIGITS-1:0] segs
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0][NIB_W-1:0] r_digits;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] w_shifted;
  logic [NIB_W-1:0]                 r_shift_out;
  logic [CNT_W-1:0]                 r_cnt;
  blink_phase_e                     r_phase;
  logic [NUM_DIGITS-1:0]            w_lz_dark;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_lut_segs;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_segs_next;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] r_segs;

  always_comb begin
    w_shifted    = r_digits;
    w_shifted[0] = shift_nibble;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      w_shifted[i] = r_digits[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_digits    <= '0;
      r_shift_out <= '0;
    end else if (load) begin
      r_digits <= value;
    end else if (shift) begin
      r_digits    <= w_shifted;
      r_shift_out <= r_digits[NUM_DIGITS-1];
    end
  end

  // Disabling blink parks the counter and phase so re-enable starts lit.
  always_ff @(posedge clock) begin
    if (reset || !blink_en) begin
      r_cnt   <= '0;
      r_phase <= PH_LIT;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_phase <= (r_phase == PH_LIT) ? PH_DARK : PH_LIT;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // Walk down from the top digit; digit 0 is always shown.
  always_comb begin
    w_lz_dark  = '0;
    w_zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run   = w_zero_run & (r_digits[i] == '0);
      w_lz_dark[i] = w_zero_run;
    end
  end
`else
  always_comb begin
    w_lz_dark = '0;
  end
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    hex_seg_lut u_lut (
      .i_nibble (r_digits[g]),
      .o_segs   (w_lut_segs[g])
    );
  end

  always_comb begin
    w_segs_next = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (blank_mask[i] || w_lz_dark[i] || (r_phase == PH_DARK)) begin
        w_segs_next[i] = BLANK_SEG;
      end else begin
        w_segs_next[i] = w_lut_segs[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_segs <= '0;
    end else begin
      r_segs <= w_segs_next;
    end
  end

  assign digits_q  = r_digits;
  assign shift_out = r_shift_out;
  assign segs      = r_segs;

endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank (4 digits, blink half-period 4 cycles).
// Stimulus queues expectations tagged with the clock edge count; a negedge monitor checks them.
module tb_hex_display_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        shift;
  logic [3:0]  shift_nibble;
  logic [3:0]  blank_mask;
  logic        blink_en;
  logic [15:0] digits_q;
  logic [3:0]  shift_out;
  logic [27:0] segs;

  hex_display_bank #(
    .NUM_DIGITS (4),
    .BLINK_DIV  (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load         (load),
    .value        (value),
    .shift        (shift),
    .shift_nibble (shift_nibble),
    .blank_mask   (blank_mask),
    .blink_en     (blink_en),
    .digits_q     (digits_q),
    .shift_out    (shift_out),
    .segs         (segs)
  );

  always #5 clock = ~clock;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] SEGS_0000    = {7'h00, 7'h00, 7'h00, 7'h3F};
  localparam logic [27:0] SEGS_0001    = {7'h00, 7'h00, 7'h00, 7'h06};
  localparam logic [27:0] SEGS_0005    = {7'h00, 7'h00, 7'h00, 7'h6D};
  localparam logic [27:0] SEGS_0005_M1 = {7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] SEGS_0005_M4 = {7'h00, 7'h00, 7'h00, 7'h6D};
`else
  localparam logic [27:0] SEGS_0000    = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [27:0] SEGS_0001    = {7'h3F, 7'h3F, 7'h3F, 7'h06};
  localparam logic [27:0] SEGS_0005    = {7'h3F, 7'h3F, 7'h3F, 7'h6D};
  localparam logic [27:0] SEGS_0005_M1 = {7'h3F, 7'h3F, 7'h3F, 7'h00};
  localparam logic [27:0] SEGS_0005_M4 = {7'h3F, 7'h00, 7'h3F, 7'h6D};
`endif

  typedef struct {
    int unsigned cyc;
    string       name;
    bit          chk_d;
    logic [15:0] d;
    bit          chk_so;
    logic [3:0]  so;
    bit          chk_s;
    logic [27:0] s;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          stim_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input string name,
                      input bit cd, input logic [15:0] d,
                      input bit cso, input logic [3:0] so,
                      input bit cs, input logic [27:0] s);
    exp_t e;
    e.cyc = c; e.name = name;
    e.chk_d = cd; e.d = d; e.chk_so = cso; e.so = so; e.chk_s = cs; e.s = s;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: expectation for edge %0d seen at edge %0d", e.name, e.cyc, cyc);
          continue;
        end
        if (e.chk_d) begin
          n_checks++;
          if (digits_q !== e.d) begin
            n_fail++;
            $display("FAIL %s digits_q @%0d: got %h expected %h", e.name, cyc, digits_q, e.d);
          end
        end
        if (e.chk_so) begin
          n_checks++;
          if (shift_out !== e.so) begin
            n_fail++;
            $display("FAIL %s shift_out @%0d: got %h expected %h", e.name, cyc, shift_out, e.so);
          end
        end
        if (e.chk_s) begin
          n_checks++;
          if (segs !== e.s) begin
            n_fail++;
            $display("FAIL %s segs @%0d: got %h expected %h", e.name, cyc, segs, e.s);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned c0;
    reset = 1'b1; load = 1'b0; value = '0; shift = 1'b0;
    shift_nibble = '0; blank_mask = '0; blink_en = 1'b0;

    // Reset and first idle edge
    push(1, "reset", 1, 16'h0000, 1, 4'h0, 1, 28'h0);
    step();
    reset = 1'b0;
    push(2, "idle_after_reset", 1, 16'h0000, 0, 4'h0, 1, SEGS_0000);
    step();

    // Parallel load then two shifts, then load overriding shift
    load = 1'b1; value = 16'h12AF;
    push(3, "load_12AF", 1, 16'h12AF, 1, 4'h0, 0, 28'h0);
    step();
    load = 1'b0; shift = 1'b1; shift_nibble = 4'h3;
    push(4, "shift_3", 1, 16'h2AF3, 1, 4'h1, 1, {7'h06, 7'h5B, 7'h77, 7'h71});
    step();
    shift_nibble = 4'h4;
    push(5, "shift_4", 1, 16'hAF34, 1, 4'h2, 1, {7'h5B, 7'h77, 7'h71, 7'h4F});
    step();
    load = 1'b1; value = 16'h0001; shift_nibble = 4'h9;
    push(6, "load_over_shift", 1, 16'h0001, 1, 4'h2, 1, {7'h77, 7'h71, 7'h4F, 7'h66});
    step();
    load = 1'b0; shift = 1'b0;
    push(7, "idle_0001", 1, 16'h0001, 1, 4'h2, 1, SEGS_0001);
    step();

    // Blink: 4 lit / 4 dark starting lit; drop enable while dark
    c0 = cyc;
    blink_en = 1'b1;
    for (int unsigned k = 1; k <= 14; k++) begin
      push(c0 + k, "blink", 0, '0, 0, '0, 1, (((k - 1) / 4) % 2 == 1) ? 28'h0 : SEGS_0001);
    end
    for (int unsigned k = 1; k <= 14; k++) step();
    blink_en = 1'b0;
    push(cyc + 1, "blink_drop_edge", 0, '0, 0, '0, 1, 28'h0);
    push(cyc + 2, "blink_relit", 0, '0, 0, '0, 1, SEGS_0001);
    step();
    step();

    // Blanking mask
    load = 1'b1; value = 16'h0005; blank_mask = 4'b0001;
    push(cyc + 1, "load_0005", 1, 16'h0005, 0, '0, 0, '0);
    step();
    load = 1'b0;
    push(cyc + 1, "mask_digit0", 0, '0, 0, '0, 1, SEGS_0005_M1);
    step();
    blank_mask = 4'b0100;
    push(cyc + 1, "mask_digit2", 0, '0, 0, '0, 1, SEGS_0005_M4);
    step();
    blank_mask = 4'b0000;
    push(cyc + 1, "no_mask", 0, '0, 0, '0, 1, SEGS_0005);
    step();

    // Reset in the middle of blinking and shifting
    c0 = cyc;
    blink_en = 1'b1; shift = 1'b1; shift_nibble = 4'h7;
    push(c0 + 3, "mid_shift", 1, 16'h5777, 1, 4'h0, 0, '0);
    push(c0 + 5, "dark_before_reset", 1, 16'h7777, 1, 4'h7, 1, 28'h0);
    for (int unsigned k = 1; k <= 5; k++) step();
    reset = 1'b1;
    push(cyc + 1, "reset_mid", 1, 16'h0000, 1, 4'h0, 1, 28'h0);
    step();
    reset = 1'b0; shift = 1'b0;
    c0 = cyc;
    push(c0 + 1, "post_reset_lit1", 0, '0, 0, '0, 1, SEGS_0000);
    push(c0 + 3, "post_reset_lit3", 0, '0, 0, '0, 1, SEGS_0000);
    push(c0 + 4, "post_reset_lit4", 0, '0, 0, '0, 1, SEGS_0000);
    push(c0 + 5, "post_reset_dark", 1, 16'h0000, 0, '0, 1, 28'h0);
    for (int unsigned k = 1; k <= 5; k++) step();
    blink_en = 1'b0;
    stim_done = 1'b1;
  end

  initial begin : finisher
    int unsigned budget;
    wait (stim_done);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
